hilo_param: RTL
===============

HILO_PARAM -- requirements
Module: hilo_param

Interface
REQ-001 Parameter NIBBLES, default 2, number of 4-bit guess digits; legal range 1..4; value width W=4*NIBBLES.
REQ-002 Parameter MAX_GUESSES, default 8, wrong-guess limit; legal range 1..15.
REQ-003 Parameter DB_CYCLES, default 200000, stable-high clocks required to accept a button press; minimum 2.
REQ-004 Port clk input 1 is the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst input 1 is the asynchronous, active-high reset.
REQ-006 Port switches input 4 is the digit entry value.
REQ-007 Port enter_btn input 1 is the raw enter button (start/next digit/continue).
REQ-008 Port restart_btn input 1 is the raw restart button.
REQ-009 Port guess_o output W is the current guess register.
REQ-010 Port count_o output 4 is the number of guesses verified since the last start.
REQ-011 Port state_o output 3 is the encoded FSM state.
REQ-012 Ports too_high, too_low, win, lose are 1-bit outputs, each high only in its matching state.

Function
REQ-013 Each button SHALL pass a 2-flop synchroniser, then a stable-high counter; one 1-cycle press pulse SHALL fire exactly DB_CYCLES+2 clocks after the raw input is first sampled high, with no further pulse until the synchronised input is sampled low.
REQ-014 A free-running W-bit counter SHALL increment every clock and wrap from all-ones to 0.
REQ-015 States: IDLE=0, ENTRY=1, VERIFY=2, HINT_HI=3, HINT_LO=4, WIN=5, LOSE=6; values 7 SHALL map to IDLE on the next clock.
REQ-016 IDLE: on enter pulse, latch answer = free-running counter value of that cycle, clear guess_o, count_o and digit index, go to ENTRY.
REQ-017 ENTRY: each enter pulse writes switches into nibble NIBBLES-1-idx (MSB first); the pulse writing the last nibble moves to VERIFY.
REQ-018 VERIFY lasts exactly one cycle: count_o increments (saturating at 15); guess==answer goes to WIN, guess>answer goes to HINT_HI, otherwise HINT_LO (unsigned compare).
REQ-019 HINT_HI/HINT_LO: the next enter pulse clears guess_o and idx and goes to ENTRY.
REQ-020 WIN and LOSE: the next enter pulse goes to IDLE; count_o and guess_o hold until then.
REQ-021 A restart pulse in any state SHALL go to IDLE next cycle and clear guess_o and count_o; it overrides a simultaneous enter pulse.
REQ-022 Output flags SHALL be registered, decoded from the state register, and never overlap.

Reset
REQ-023 rst SHALL asynchronously force state IDLE and set guess_o, count_o, answer, idx, the free-running counter, the debounce counters and the synchronisers to 0.
REQ-024 Reset asserted mid-game SHALL discard all progress; no press pulse SHALL be emitted within DB_CYCLES+2 clocks after deassertion.

Configuration
REQ-025 With HILO_LOSE_LIMIT_EN defined, VERIFY on a wrong guess with post-increment count_o == MAX_GUESSES SHALL go to LOSE instead of HINT_HI/HINT_LO.
REQ-026 Without HILO_LOSE_LIMIT_EN, LOSE is unreachable, lose stays 0, and guessing is unlimited.

Structure
REQ-027 State encodings, NIBBLES range limits and the 4-bit digit width SHALL live in shared package hilo_pkg.
REQ-028 The synchroniser and debounce logic SHALL be one sub-module, btn_pulse, instantiated once per button.

Verification (DB_CYCLES=4, NIBBLES=2, MAX_GUESSES=3)
REQ-029 enter_btn held high from cycle 0 -> exactly one pulse at cycle 6, none after; a 3-cycle glitch -> no pulse.
REQ-030 Start when counter=0x5A; enter 0x3 then 0xC -> guess_o=0x3C, VERIFY, HINT_LO, too_low=1, count_o=1.
REQ-031 Answer 0x5A; guesses 0x70, then 0x5A -> HINT_HI with too_high=1, then WIN with win=1 and count_o=2.
REQ-032 With HILO_LOSE_LIMIT_EN, answer 0x5A, three wrong guesses -> LOSE, lose=1, count_o=3; without the macro -> HINT after the third guess and count_o=3.
REQ-033 Enter and restart pulses in the same cycle during ENTRY -> IDLE, guess_o=0, count_o=0.
REQ-034 rst asserted mid-ENTRY with one nibble entered -> state_o=0 and all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the hi/lo guessing game: state encoding, digit width
// and the legal range of the NIBBLES parameter.
package hilo_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NIBBLES_MIN = 1;
    localparam int NIBBLES_MAX = 4;
    localparam int COUNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_HINT_HI = 3'd3,
        ST_HINT_LO = 3'd4,
        ST_WIN     = 3'd5,
        ST_LOSE    = 3'd6
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hilo_param_btn_pulse.sv
// Button conditioner: 2-flop synchroniser followed by a stable-high counter that
// emits a single 1-cycle pulse per press, DB_CYCLES+2 clocks after first sample.
module btn_pulse #(
    parameter int DB_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = $clog2(DB_CYCLES + 2);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // Counter parks at DB_CYCLES+1 after firing so a held button cannot re-fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES)) begin
                r_cnt   <= CW'(DB_CYCLES + 1);
                r_pulse <= 1'b1;
            end else if (r_cnt < CW'(DB_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/hilo_param.sv
// Hi/lo number guessing game top. Optional lose limit enabled by defining
// HILO_LOSE_LIMIT_EN; otherwise guessing is unlimited and LOSE is unreachable.
module hilo_param
    import hilo_pkg::*;
#(
    parameter int NIBBLES     = 2,
    parameter int MAX_GUESSES = 8,
    parameter int DB_CYCLES   = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGIT_W-1:0]     switches,
    input  logic                   enter_btn,
    input  logic                   restart_btn,
    output logic [4*NIBBLES-1:0]   guess_o,
    output logic [COUNT_W-1:0]     count_o,
    output logic [2:0]             state_o,
    output logic                   too_high,
    output logic                   too_low,
    output logic                   win,
    output logic                   lose
);

    localparam int W = DIGIT_W * NIBBLES;

`ifdef HILO_LOSE_LIMIT_EN
    localparam bit LOSE_EN = 1'b1;
`else
    localparam bit LOSE_EN = 1'b0;
`endif

    logic               w_enter_p;
    logic               w_restart_p;

    state_t             r_state;
    logic [W-1:0]       r_guess;
    logic [COUNT_W-1:0] r_count;
    logic [W-1:0]       r_answer;
    logic [1:0]         r_idx;
    logic [W-1:0]       r_free;
    logic               r_too_high;
    logic               r_too_low;
    logic               r_win;
    logic               r_lose;

    state_t             w_state_nxt;
    logic [W-1:0]       w_guess_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [W-1:0]       w_answer_nxt;
    logic [1:0]         w_idx_nxt;
    logic [COUNT_W-1:0] w_count_inc;
    logic               w_eq;
    logic               w_gt;
    logic               w_lose_hit;

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (enter_btn),
        .o_pulse (w_enter_p)
    );

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_restart (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (restart_btn),
        .o_pulse (w_restart_p)
    );

    assign w_count_inc = sat_inc(r_count);
    assign w_eq        = (r_guess == r_answer);
    assign w_gt        = (r_guess > r_answer);
    assign w_lose_hit  = LOSE_EN && (w_count_inc == COUNT_W'(MAX_GUESSES));

    always_comb begin
        w_state_nxt  = r_state;
        w_guess_nxt  = r_guess;
        w_count_nxt  = r_count;
        w_answer_nxt = r_answer;
        w_idx_nxt    = r_idx;
        if (w_restart_p) begin
            w_state_nxt = ST_IDLE;
            w_guess_nxt = '0;
            w_count_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_enter_p) begin
                        w_answer_nxt = r_free;
                        w_guess_nxt  = '0;
                        w_count_nxt  = '0;
                        w_idx_nxt    = '0;
                        w_state_nxt  = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (w_enter_p) begin
                        // Digits are entered most-significant nibble first.
                        for (int n = 0; n < NIBBLES; n++) begin
                            if (n == NIBBLES - 1 - int'(r_idx)) begin
                                w_guess_nxt[n*DIGIT_W +: DIGIT_W] = switches;
                            end
                        end
                        if (r_idx == 2'(NIBBLES - 1)) begin
                            w_state_nxt = ST_VERIFY;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    w_count_nxt = w_count_inc;
                    if (w_eq) begin
                        w_state_nxt = ST_WIN;
                    end else if (w_lose_hit) begin
                        w_state_nxt = ST_LOSE;
                    end else if (w_gt) begin
                        w_state_nxt = ST_HINT_HI;
                    end else begin
                        w_state_nxt = ST_HINT_LO;
                    end
                end
                ST_HINT_HI, ST_HINT_LO: begin
                    if (w_enter_p) begin
                        w_guess_nxt = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_ENTRY;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (w_enter_p) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_guess    <= '0;
            r_count    <= '0;
            r_answer   <= '0;
            r_idx      <= '0;
            r_free     <= '0;
            r_too_high <= 1'b0;
            r_too_low  <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_guess    <= w_guess_nxt;
            r_count    <= w_count_nxt;
            r_answer   <= w_answer_nxt;
            r_idx      <= w_idx_nxt;
            r_free     <= r_free + 1'b1;
            r_too_high <= (w_state_nxt == ST_HINT_HI);
            r_too_low  <= (w_state_nxt == ST_HINT_LO);
            r_win      <= (w_state_nxt == ST_WIN);
            r_lose     <= (w_state_nxt == ST_LOSE);
        end
    end

    assign guess_o  = r_guess;
    assign count_o  = r_count;
    assign state_o  = r_state;
    assign too_high = r_too_high;
    assign too_low  = r_too_low;
    assign win      = r_win;
    assign lose     = r_lose;

endmodule
